issue_ctrl: RTL and testbench

- In-order dual-issue controller between decode and the two execute pipes.
- Buffers decoded instructions in a small queue and drives the register scoreboard's read-address, write-address and issue-strobe ports.
- Each cycle, issues 0, 1 or 2 head instructions, based on:
  - scoreboard operand readiness,
  - intra-pair hazards,
  - a single-memory-port structural rule.
- Obeys the scoreboard's issue-ready (invalidate wait) and a pipeline flush.

---
 rtl/issue_ctrl.sv | 129 ++++++++++++
 tb/tb_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order dual-issue controller with decode queue and scoreboard handshake
// Optional perf counters (perf_dual_o, perf_single_o, perf_stall_o) enabled by ISSUE_CTRL_PERF_EN.
module issue_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [1:0]             dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [1:0][DATA_W-1:0] dec_data_i,
  input  logic [1:0][4:0]        dec_rj_i,
  input  logic [1:0][4:0]        dec_rk_i,
  input  logic [1:0][4:0]        dec_rd_i,
  input  logic [1:0]             dec_mem_i,
  output logic [3:0][4:0]        sb_r_addr_o,
  input  logic [3:0]             sb_r_valid_i,
  output logic [1:0][4:0]        sb_w_addr_o,
  output logic [1:0]             sb_is_o,
  input  logic                   sb_ready_i,
  input  logic                   ex_ready_i,
  output logic [1:0]             is_valid_o,
  output logic [1:0][DATA_W-1:0] is_data_o
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_dual_o,
  output logic [31:0]            perf_single_o,
  output logic [31:0]            perf_stall_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [4:0]        rj_q   [DEPTH];
  logic [4:0]        rk_q   [DEPTH];
  logic [4:0]        rd_q   [DEPTH];
  logic [DEPTH-1:0]  mem_q;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] h1_ptr, tail1_ptr;

  logic       gate, iss0, iss1, raw, waw, mem_conf;
  logic       enq0, enq1;
  logic [1:0] iss_n, enq_n;

  assign h1_ptr    = head_q + PW'(1);
  assign tail1_ptr = tail_q + PW'(1);

  // Room for a full decode pair; ignores same-cycle dequeues on purpose.
  assign dec_ready_o = (count_q <= CW'(DEPTH - 2));

  // Head views feed the scoreboard unconditionally; stale reads are harmless.
  assign sb_r_addr_o = {rk_q[h1_ptr], rj_q[h1_ptr], rk_q[head_q], rj_q[head_q]};
  assign sb_w_addr_o = {rd_q[h1_ptr], rd_q[head_q]};
  assign is_data_o   = {data_q[h1_ptr], data_q[head_q]};
  assign is_valid_o  = {iss1, iss0};
  assign sb_is_o     = {iss1, iss0};

  // Issue selection: h0 on operand readiness, h1 additionally on pair hazards.
  always_comb begin
    gate     = !flush_i && sb_ready_i && ex_ready_i;
    raw      = (rd_q[head_q] != 5'd0) &&
               ((rd_q[head_q] == rj_q[h1_ptr]) || (rd_q[head_q] == rk_q[h1_ptr]));
    waw      = (rd_q[head_q] != 5'd0) && (rd_q[head_q] == rd_q[h1_ptr]);
    mem_conf = mem_q[head_q] && mem_q[h1_ptr];
    iss0     = gate && (count_q != '0) && sb_r_valid_i[0] && sb_r_valid_i[1];
    iss1     = iss0 && (count_q >= CW'(2)) && sb_r_valid_i[2] && sb_r_valid_i[3] &&
               !raw && !waw && !mem_conf;
    enq0     = !flush_i && dec_ready_o && dec_valid_i[0];
    enq1     = enq0 && dec_valid_i[1];
    iss_n    = {1'b0, iss0} + {1'b0, iss1};
    enq_n    = {1'b0, enq0} + {1'b0, enq1};
  end

  // Queue pointers and occupancy; flush empties and rewinds the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(iss_n);
      tail_q  <= tail_q + PW'(enq_n);
      count_q <= count_q + CW'(enq_n) - CW'(iss_n);
    end
  end

  // Entry storage written at the tail in slot order; contents are not reset.
  always_ff @(posedge clk) begin
    if (enq0) begin
      data_q[tail_q] <= dec_data_i[0];
      rj_q[tail_q]   <= dec_rj_i[0];
      rk_q[tail_q]   <= dec_rk_i[0];
      rd_q[tail_q]   <= dec_rd_i[0];
      mem_q[tail_q]  <= dec_mem_i[0];
    end
    if (enq1) begin
      data_q[tail1_ptr] <= dec_data_i[1];
      rj_q[tail1_ptr]   <= dec_rj_i[1];
      rk_q[tail1_ptr]   <= dec_rk_i[1];
      rd_q[tail1_ptr]   <= dec_rd_i[1];
      mem_q[tail1_ptr]  <= dec_mem_i[1];
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  // Saturating issue statistics; survive flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dual_o   <= '0;
      perf_single_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (iss1 && !(&perf_dual_o)) perf_dual_o <= perf_dual_o + 32'd1;
      if (iss0 && !iss1 && !(&perf_single_o)) perf_single_o <= perf_single_o + 32'd1;
      if ((count_q != '0) && !iss0 && !(&perf_stall_o)) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scoreboard bench for issue_ctrl against a queue-based reference model
module tb_issue_ctrl;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [4:0]  rd;
    logic        mem;
  } ent_t;

  typedef struct {
    logic [1:0] v;
    logic       rdy;
    int         n;
    ent_t       h0;
    ent_t       h1;
    logic       dv_en;
    logic [1:0] dv;
    logic       dr_en;
    logic       dr;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush_i = 1'b0;
  logic [1:0]             dec_valid_i = '0;
  logic                   dec_ready_o;
  logic [1:0][DATA_W-1:0] dec_data_i = '0;
  logic [1:0][4:0]        dec_rj_i = '0;
  logic [1:0][4:0]        dec_rk_i = '0;
  logic [1:0][4:0]        dec_rd_i = '0;
  logic [1:0]             dec_mem_i = '0;
  logic [3:0][4:0]        sb_r_addr_o;
  logic [3:0]             sb_r_valid_i = '0;
  logic [1:0][4:0]        sb_w_addr_o;
  logic [1:0]             sb_is_o;
  logic                   sb_ready_i = 1'b0;
  logic                   ex_ready_i = 1'b0;
  logic [1:0]             is_valid_o;
  logic [1:0][DATA_W-1:0] is_data_o;

  issue_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_data_i(dec_data_i), .dec_rj_i(dec_rj_i), .dec_rk_i(dec_rk_i),
    .dec_rd_i(dec_rd_i), .dec_mem_i(dec_mem_i),
    .sb_r_addr_o(sb_r_addr_o), .sb_r_valid_i(sb_r_valid_i),
    .sb_w_addr_o(sb_w_addr_o), .sb_is_o(sb_is_o),
    .sb_ready_i(sb_ready_i), .ex_ready_i(ex_ready_i),
    .is_valid_o(is_valid_o), .is_data_o(is_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ent_t mq[$];
  exp_t exp_q[$];

  // staged stimulus for the next step
  logic       s_fl = 1'b0, s_sbr = 1'b1, s_exr = 1'b1;
  logic [1:0] s_dv = '0;
  logic [3:0] s_rv = 4'hf;
  ent_t       s_e[2];
  logic       s_dv_en = 1'b0, s_dr_en = 1'b0, s_dr = 1'b0;
  logic [1:0] s_dvx = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input int rj, input int rk, input int rd, input bit mem);
    s_e[s].data = {$urandom, $urandom};
    s_e[s].rj = 5'(rj);
    s_e[s].rk = 5'(rk);
    s_e[s].rd = 5'(rd);
    s_e[s].mem = mem;
  endtask

  // Apply staged inputs for one cycle, predict the outputs, advance the model.
  task automatic step();
    exp_t e;
    int   n;
    logic g, e0, e1, raw, waw;
    @(posedge clk);
    #1;
    flush_i = s_fl; dec_valid_i = s_dv; sb_r_valid_i = s_rv;
    sb_ready_i = s_sbr; ex_ready_i = s_exr;
    for (int s = 0; s < 2; s++) begin
      dec_data_i[s] = s_e[s].data; dec_rj_i[s] = s_e[s].rj; dec_rk_i[s] = s_e[s].rk;
      dec_rd_i[s] = s_e[s].rd; dec_mem_i[s] = s_e[s].mem;
    end
    n  = mq.size();
    g  = !s_fl && s_sbr && s_exr;
    e0 = g && n >= 1 && s_rv[0] && s_rv[1];
    e1 = 1'b0;
    if (e0 && n >= 2) begin
      raw = mq[0].rd != 0 && (mq[0].rd == mq[1].rj || mq[0].rd == mq[1].rk);
      waw = mq[0].rd != 0 && mq[0].rd == mq[1].rd;
      e1  = s_rv[2] && s_rv[3] && !raw && !waw && !(mq[0].mem && mq[1].mem);
    end
    e.v = {e1, e0};
    e.rdy = (DEPTH - n) >= 2;
    e.n = n;
    e.h0 = (n >= 1) ? mq[0] : '0;
    e.h1 = (n >= 2) ? mq[1] : '0;
    e.dv_en = s_dv_en; e.dv = s_dvx; e.dr_en = s_dr_en; e.dr = s_dr;
    exp_q.push_back(e);
    if (s_fl) mq.delete();
    else begin
      if (e0) void'(mq.pop_front());
      if (e1) void'(mq.pop_front());
      if (e.rdy && s_dv[0]) begin
        mq.push_back(s_e[0]);
        if (s_dv[1]) mq.push_back(s_e[1]);
      end
    end
    s_dv_en = 1'b0; s_dr_en = 1'b0;
  endtask

  task automatic expect_v(input logic [1:0] v);
    s_dv_en = 1'b1; s_dvx = v;
  endtask

  task automatic expect_r(input logic r);
    s_dr_en = 1'b1; s_dr = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    flush_i = 1'b0; dec_valid_i = 2'b11; sb_r_valid_i = 4'hf;
    sb_ready_i = 1'b1; ex_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_is_valid", 64'(is_valid_o), 64'd0);
    chk("rst_dec_ready", 64'(dec_ready_o), 64'd1);
    mq.delete();
    #8;
    dec_valid_i = 2'b00;
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pop one prediction per cycle and compare on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("is_valid", 64'(is_valid_o), 64'(e.v));
      chk("sb_is", 64'(sb_is_o), 64'(e.v));
      chk("dec_ready", 64'(dec_ready_o), 64'(e.rdy));
      if (e.dv_en) chk("dir_is_valid", 64'(is_valid_o), 64'(e.dv));
      if (e.dr_en) chk("dir_dec_ready", 64'(dec_ready_o), 64'(e.dr));
      if (e.v[0]) chk("is_data0", is_data_o[0], e.h0.data);
      if (e.v[1]) chk("is_data1", is_data_o[1], e.h1.data);
      if (e.n >= 1) begin
        chk("w_addr0", 64'(sb_w_addr_o[0]), 64'(e.h0.rd));
        chk("r_addr0", 64'(sb_r_addr_o[0]), 64'(e.h0.rj));
        chk("r_addr1", 64'(sb_r_addr_o[1]), 64'(e.h0.rk));
      end
      if (e.n >= 2) begin
        chk("w_addr1", 64'(sb_w_addr_o[1]), 64'(e.h1.rd));
        chk("r_addr2", 64'(sb_r_addr_o[2]), 64'(e.h1.rj));
        chk("r_addr3", 64'(sb_r_addr_o[3]), 64'(e.h1.rk));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    set_slot(0, 0, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0);
    #7;
    chk("reset_is_valid", 64'(is_valid_o), 64'd0);
    chk("reset_dec_ready", 64'(dec_ready_o), 64'd1);
    #5;
    rst_n = 1'b1;

    // idle
    step(); step();

    // independent pair
    set_slot(0, 1, 2, 5, 0); set_slot(1, 3, 4, 6, 0);
    s_dv = 2'b11; step();
    s_dv = 2'b00; expect_v(2'b11); step();
    expect_v(2'b00); expect_r(1'b1); step();

    // RAW split
    set_slot(0, 1, 2, 7, 0); set_slot(1, 7, 3, 8, 0);
    s_dv = 2'b11; step();
    s_dv = 2'b00; expect_v(2'b01); step();
    expect_v(2'b01); step();

    // operand stall
    set_slot(0, 1, 2, 9, 0); set_slot(1, 3, 4, 10, 1);
    s_dv = 2'b11; step();
    s_dv = 2'b00; s_rv = 4'b1101;
    for (int i = 0; i < 3; i++) begin expect_v(2'b00); step(); end
    s_rv = 4'hf; expect_v(2'b11); step();

    // full queue
    s_exr = 1'b0;
    set_slot(0, 1, 2, 11, 0); set_slot(1, 3, 4, 12, 0); s_dv = 2'b11; step();
    set_slot(0, 5, 6, 13, 0); set_slot(1, 7, 8, 14, 0); step();
    set_slot(0, 9, 9, 15, 0); set_slot(1, 9, 9, 16, 0); expect_r(1'b0); step();
    s_dv = 2'b00; s_exr = 1'b1; expect_v(2'b11); expect_r(1'b0); step();
    expect_v(2'b11); expect_r(1'b1); step();
    step();

    // flush, then scoreboard wait
    s_exr = 1'b0;
    set_slot(0, 1, 2, 3, 0); set_slot(1, 4, 5, 6, 0); s_dv = 2'b11; step();
    s_dv = 2'b01; step();
    s_fl = 1'b1; s_dv = 2'b11; s_exr = 1'b1; expect_v(2'b00); step();
    s_fl = 1'b0; s_dv = 2'b00; s_sbr = 1'b0; expect_v(2'b00); expect_r(1'b1); step();
    set_slot(0, 1, 2, 20, 0); set_slot(1, 3, 4, 21, 0); s_dv = 2'b11; expect_v(2'b00); step();
    s_dv = 2'b00; expect_v(2'b00); step();
    s_sbr = 1'b1; expect_v(2'b11); step();

    // randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      r = $urandom_range(0, 3);
      s_dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      for (int s = 0; s < 2; s++)
        set_slot(s, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1);
      s_fl  = ($urandom_range(0, 15) == 0);
      s_sbr = ($urandom_range(0, 7) != 0);
      s_exr = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < 4; b++) s_rv[b] = ($urandom_range(0, 7) != 0);
      step();
    end

    @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
